mvu_controller: RTL and testbench

- Bit-serial job sequencer that sits directly upstream of the mvu block and drives its control and address inputs.
- For each output tile it issues weight/data bit-plane address pairs in descending-significance order and controls accumulator clear/shift.
- It then triggers the quantizer and writes the quantized bit planes back to data memory.
- Software or a host FSM loads a job descriptor and pulses start; the controller reports busy/done/err.

---
 rtl/mvu_controller_if.sv | 58 +++++
 rtl/mvu_controller.sv | 244 ++++++++++++++++++++++++
 tb/tb_mvu_controller.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mvu_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : mvu_controller_if
//  Description : Control/address bus between mvu_controller and the mvu
//                datapath. The controller is the master. It drives the
//                accumulator, quantizer and memory request lines. The mvu
//                side returns the read and write grants.
//                Signals:
//                  mul_mode, acc_clr, acc_sh     multiplier / accumulator ctl
//                  max_en, max_clr, max_pool     max-pool ctl (unused, tied 0)
//                  quant_clr, quant_msbidx,
//                  quant_bdout, quant_start      quantizer ctl
//                  rdw_addr, rdd_en, rdd_addr    bit-plane read issue
//                  rdd_grnt                      issue accepted
//                  wrd_en, wrd_addr              quantized write-back
//                  wrd_grnt                      write accepted
//  Revision    : 1.0 - initial release
// ============================================================================
interface mvu_controller_if #(
    parameter int BWBANKA   = 9,
    parameter int BDBANKA   = 14,
    parameter int BACC      = 32,
    parameter int QMSBLOCBD = $clog2(BACC),
    parameter int QBDOUTBD  = $clog2(BACC)
);
    logic [1:0]           mul_mode;
    logic                 acc_clr;
    logic                 acc_sh;
    logic                 max_en;
    logic                 max_clr;
    logic                 max_pool;
    logic                 quant_clr;
    logic [QMSBLOCBD-1:0] quant_msbidx;
    logic [QBDOUTBD-1:0]  quant_bdout;
    logic                 quant_start;
    logic [BWBANKA-1:0]   rdw_addr;
    logic                 rdd_en;
    logic                 rdd_grnt;
    logic [BDBANKA-1:0]   rdd_addr;
    logic                 wrd_en;
    logic                 wrd_grnt;
    logic [BDBANKA-1:0]   wrd_addr;

    modport master (
        output mul_mode, acc_clr, acc_sh, max_en, max_clr, max_pool,
               quant_clr, quant_msbidx, quant_bdout, quant_start,
               rdw_addr, rdd_en, rdd_addr, wrd_en, wrd_addr,
        input  rdd_grnt, wrd_grnt
    );

    modport slave (
        input  mul_mode, acc_clr, acc_sh, max_en, max_clr, max_pool,
               quant_clr, quant_msbidx, quant_bdout, quant_start,
               rdw_addr, rdd_en, rdd_addr, wrd_en, wrd_addr,
        output rdd_grnt, wrd_grnt
    );
endinterface
`default_nettype wire

// File: rtl/mvu_controller.sv
`default_nettype none
// ============================================================================
//  Module      : mvu_controller
//  Description : Bit-serial job sequencer for the mvu. For each output tile
//                it issues weight/data bit-plane address pairs from the most
//                significant product level down to the least significant one.
//                It waits out the mvu pipeline, fires the quantizer and
//                streams the quantized bit planes back to data memory.
//                Ports:
//                  clk, rst_n     clock, synchronous active-low reset
//                  start, cfg_*   job descriptor, latched on start in IDLE
//                  busy/done/err  job status (err is sticky until next start)
//                  mvu            master side of mvu_controller_if
//  Revision    : 1.0 - initial release
// ============================================================================
module mvu_controller #(
    parameter int BWBANKA   = 9,
    parameter int BDBANKA   = 14,
    parameter int BACC      = 32,
    parameter int QMSBLOCBD = $clog2(BACC),
    parameter int QBDOUTBD  = $clog2(BACC),
    parameter int PIPE_LAT  = 3,
    parameter int QLAT      = 2,
    parameter int PRECW     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           cfg_mul_mode,
    input  logic [PRECW-1:0]     cfg_wprec,
    input  logic [PRECW-1:0]     cfg_dprec,
    input  logic [7:0]           cfg_ntile,
    input  logic [BWBANKA-1:0]   cfg_wbase,
    input  logic [BDBANKA-1:0]   cfg_dbase,
    input  logic [BDBANKA-1:0]   cfg_obase,
    input  logic [QMSBLOCBD-1:0] cfg_qmsbidx,
    input  logic [QBDOUTBD-1:0]  cfg_qbdout,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    mvu_controller_if.master     mvu
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_ISSUE = 3'd1;
    localparam logic [2:0] c_DRAIN = 3'd2;
    localparam logic [2:0] c_QUANT = 3'd3;
    localparam logic [2:0] c_WRITE = 3'd4;
    localparam logic [2:0] c_DONE  = 3'd5;

    // Precisions and significance counters carry one extra bit so that the
    // top significance W+D-2 (up to 28) fits without a separate width.
    localparam logic [PRECW:0] c_ONE = {{PRECW{1'b0}}, 1'b1};

    logic [2:0]           r_state;
    logic [1:0]           r_mul_mode;
    logic [PRECW:0]       r_wprec;
    logic [PRECW:0]       r_dprec;
    logic [7:0]           r_ntile;
    logic [BWBANKA-1:0]   r_wbase;
    logic [BDBANKA-1:0]   r_dbase;
    logic [BDBANKA-1:0]   r_obase;
    logic [QMSBLOCBD-1:0] r_qmsbidx;
    logic [QBDOUTBD-1:0]  r_qbdout;
    logic [7:0]           r_tile;
    logic [PRECW:0]       r_s;      // current significance level
    logic [PRECW:0]       r_i;      // current weight bit
    logic [7:0]           r_cnt;    // drain / quantizer latency counter
    logic [QBDOUTBD-1:0]  r_k;      // write-back word index
    logic                 r_err;

    logic [PRECW:0]       w_cfg_w;
    logic [PRECW:0]       w_cfg_d;
    logic [PRECW:0]       w_cfg_top;
    logic [PRECW:0]       w_wm1;
    logic [PRECW:0]       w_dm1;
    logic [PRECW:0]       w_top;
    logic [PRECW:0]       w_ihi;
    logic [PRECW:0]       w_ilo;
    logic [PRECW:0]       w_s_dn;
    logic [PRECW:0]       w_ihi_dn;
    logic                 w_issue;
    logic                 w_write;
    logic                 w_first;
    logic                 w_last_tile;

    // A precision of zero is treated as one bit.
    assign w_cfg_w   = (cfg_wprec == '0) ? c_ONE : {1'b0, cfg_wprec};
    assign w_cfg_d   = (cfg_dprec == '0) ? c_ONE : {1'b0, cfg_dprec};
    assign w_cfg_top = (w_cfg_w - c_ONE) + (w_cfg_d - c_ONE);

    assign w_wm1 = r_wprec - c_ONE;
    assign w_dm1 = r_dprec - c_ONE;
    assign w_top = w_wm1 + w_dm1;

    // Weight-bit range for level s: i in [max(0, s-D+1), min(s, W-1)].
    assign w_ihi    = (r_s < w_wm1) ? r_s : w_wm1;
    assign w_ilo    = (r_s > w_dm1) ? (r_s - w_dm1) : '0;
    assign w_s_dn   = r_s - c_ONE;
    assign w_ihi_dn = (w_s_dn < w_wm1) ? w_s_dn : w_wm1;

    assign w_issue     = (r_state == c_ISSUE);
    assign w_write     = (r_state == c_WRITE);
    assign w_first     = w_issue && (r_s == w_top) && (r_i == w_wm1);
    assign w_last_tile = (r_tile == (r_ntile - 8'd1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_mul_mode <= '0;
            r_wprec    <= '0;
            r_dprec    <= '0;
            r_ntile    <= '0;
            r_wbase    <= '0;
            r_dbase    <= '0;
            r_obase    <= '0;
            r_qmsbidx  <= '0;
            r_qbdout   <= '0;
            r_tile     <= '0;
            r_s        <= '0;
            r_i        <= '0;
            r_cnt      <= '0;
            r_k        <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_mul_mode <= cfg_mul_mode;
                        r_wprec    <= w_cfg_w;
                        r_dprec    <= w_cfg_d;
                        r_ntile    <= cfg_ntile;
                        r_wbase    <= cfg_wbase;
                        r_dbase    <= cfg_dbase;
                        r_obase    <= cfg_obase;
                        r_qmsbidx  <= cfg_qmsbidx;
                        r_qbdout   <= cfg_qbdout;
                        r_err      <= 1'b0;
                        r_tile     <= '0;
                        r_s        <= w_cfg_top;
                        r_i        <= w_cfg_w - c_ONE;
                        r_state    <= (cfg_ntile == 8'd0) ? c_DONE : c_ISSUE;
                    end
                end

                c_ISSUE: begin
                    // Counters advance only on a granted issue, so a stalled
                    // issue keeps presenting the same address/control values.
                    if (mvu.rdd_grnt) begin
                        if (r_i == w_ilo) begin
                            if (r_s == '0) begin
                                r_cnt   <= '0;
                                r_state <= (PIPE_LAT <= 1) ? c_QUANT : c_DRAIN;
                            end else begin
                                r_s <= w_s_dn;
                                r_i <= w_ihi_dn;
                            end
                        end else begin
                            r_i <= r_i - c_ONE;
                        end
                    end
                end

                c_DRAIN: begin
                    // Covers the cycles between the last grant and quant_start.
                    if (r_cnt == 8'(PIPE_LAT - 2)) begin
                        r_cnt   <= '0;
                        r_state <= c_QUANT;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                c_QUANT: begin
                    if (r_cnt == 8'(QLAT - 1)) begin
                        r_k     <= '0;
                        r_state <= c_WRITE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                c_WRITE: begin
                    // The quantizer output cannot be held back, so a refused
                    // write is only flagged.
                    if (!mvu.wrd_grnt) begin
                        r_err <= 1'b1;
                    end
                    if (r_k == r_qbdout) begin
                        if (w_last_tile) begin
                            r_state <= c_DONE;
                        end else begin
                            r_tile  <= r_tile + 8'd1;
                            r_s     <= w_top;
                            r_i     <= w_wm1;
                            r_state <= c_ISSUE;
                        end
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end

                c_DONE: begin
                    r_state <= c_IDLE;
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != c_IDLE) && (r_state != c_DONE);
    assign done = (r_state == c_DONE);
    assign err  = r_err;

    assign mvu.mul_mode     = r_mul_mode;
    assign mvu.acc_clr      = w_first;
    assign mvu.quant_clr    = w_first;
    // Shift on entering each lower level: first issue of a level except the top one.
    assign mvu.acc_sh       = w_issue && (r_s != w_top) && (r_i == w_ihi);
    assign mvu.max_en       = 1'b0;
    assign mvu.max_clr      = 1'b0;
    assign mvu.max_pool     = 1'b0;
    assign mvu.quant_msbidx = r_qmsbidx;
    assign mvu.quant_bdout  = r_qbdout;
    assign mvu.quant_start  = (r_state == c_QUANT) && (r_cnt == 8'd0);

    assign mvu.rdd_en   = w_issue;
    assign mvu.rdw_addr = w_issue
                        ? (r_wbase + BWBANKA'(r_tile) * BWBANKA'(r_wprec) + BWBANKA'(r_i))
                        : '0;
    assign mvu.rdd_addr = w_issue ? (r_dbase + BDBANKA'(r_s - r_i)) : '0;

    assign mvu.wrd_en   = w_write;
    assign mvu.wrd_addr = w_write
                        ? (r_obase
                           + BDBANKA'(r_tile) * (BDBANKA'(r_qbdout) + BDBANKA'(1))
                           + BDBANKA'(r_k))
                        : '0;

endmodule
`default_nettype wire

// File: tb/tb_mvu_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mvu_controller
//  Description : Scoreboard bench for mvu_controller. Each job pushes its
//                expected issue and write sequences into queues, and a
//                negedge monitor pops and compares them as the DUT produces
//                them, together with the pipeline timing relations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mvu_controller;

    localparam int BWBANKA   = 9;
    localparam int BDBANKA   = 14;
    localparam int BACC      = 32;
    localparam int QMSBLOCBD = 5;
    localparam int QBDOUTBD  = 5;
    localparam int PIPE_LAT  = 3;
    localparam int QLAT      = 2;
    localparam int PRECW     = 4;

    typedef struct packed {
        logic [BWBANKA-1:0] rdw;
        logic [BDBANKA-1:0] rdd;
        logic               clr;
        logic               sh;
        logic               qclr;
    } iss_t;

    typedef struct {
        logic [BDBANKA-1:0] addr;
        bit                 first;
        bit                 last;
    } wr_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [1:0]           cfg_mul_mode = '0;
    logic [PRECW-1:0]     cfg_wprec = '0;
    logic [PRECW-1:0]     cfg_dprec = '0;
    logic [7:0]           cfg_ntile = '0;
    logic [BWBANKA-1:0]   cfg_wbase = '0;
    logic [BDBANKA-1:0]   cfg_dbase = '0;
    logic [BDBANKA-1:0]   cfg_obase = '0;
    logic [QMSBLOCBD-1:0] cfg_qmsbidx = '0;
    logic [QBDOUTBD-1:0]  cfg_qbdout = '0;
    logic                 busy;
    logic                 done;
    logic                 err;

    mvu_controller_if #(
        .BWBANKA(BWBANKA), .BDBANKA(BDBANKA), .BACC(BACC),
        .QMSBLOCBD(QMSBLOCBD), .QBDOUTBD(QBDOUTBD)
    ) mvu ();

    mvu_controller #(
        .BWBANKA(BWBANKA), .BDBANKA(BDBANKA), .BACC(BACC),
        .QMSBLOCBD(QMSBLOCBD), .QBDOUTBD(QBDOUTBD),
        .PIPE_LAT(PIPE_LAT), .QLAT(QLAT), .PRECW(PRECW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_mul_mode(cfg_mul_mode), .cfg_wprec(cfg_wprec), .cfg_dprec(cfg_dprec),
        .cfg_ntile(cfg_ntile), .cfg_wbase(cfg_wbase), .cfg_dbase(cfg_dbase),
        .cfg_obase(cfg_obase), .cfg_qmsbidx(cfg_qmsbidx), .cfg_qbdout(cfg_qbdout),
        .busy(busy), .done(done), .err(err),
        .mvu(mvu)
    );

    initial forever #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    iss_t iq[$];
    wr_t  wq[$];

    bit mon_en = 0;
    bit prev_rdd = 0;
    int n_grant, n_writes, n_qs, n_done, n_extra;
    int last_grant_cyc, qs_cyc, last_wr_cyc, next_first_cyc, done_cyc;
    int hold_issue = -1;
    int hold_left  = 0;
    int drop_wr    = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_ctrl"}, 64'({busy, done, err, mvu.mul_mode, mvu.acc_clr, mvu.acc_sh,
                                   mvu.max_en, mvu.max_clr, mvu.max_pool, mvu.quant_clr,
                                   mvu.quant_start, mvu.rdd_en, mvu.wrd_en}), 64'(0));
        check({tag, "_fields"}, 64'({mvu.quant_msbidx, mvu.quant_bdout, mvu.rdw_addr}), 64'(0));
        check({tag, "_addr"}, 64'({mvu.rdd_addr, mvu.wrd_addr}), 64'(0));
    endtask

    // Grant drivers: optional read stall on one issue, optional refused write.
    initial begin
        mvu.rdd_grnt = 1'b1;
        mvu.wrd_grnt = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (mvu.rdd_en && n_grant == hold_issue && hold_left > 0) begin
                mvu.rdd_grnt = 1'b0;
                hold_left--;
            end else begin
                mvu.rdd_grnt = 1'b1;
            end
            mvu.wrd_grnt = !(mvu.wrd_en && n_writes == drop_wr);
        end
    end

    // Monitor: compare DUT activity against the expectation queues.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mvu.rdd_en) begin
                if (!prev_rdd) check("first_issue_cyc", 64'(cyc), 64'(next_first_cyc));
                if (iq.size() == 0) begin
                    n_extra++;
                end else begin
                    check("issue", 64'(iss_t'({mvu.rdw_addr, mvu.rdd_addr, mvu.acc_clr,
                                              mvu.acc_sh, mvu.quant_clr})), 64'(iq[0]));
                    if (mvu.rdd_grnt) begin
                        void'(iq.pop_front());
                        last_grant_cyc = cyc;
                        n_grant++;
                    end
                end
            end
            if (mvu.quant_start) begin
                n_qs++;
                qs_cyc = cyc;
                check("qs_cyc", 64'(cyc), 64'(last_grant_cyc + PIPE_LAT));
                check("qs_rdd_idle", 64'(mvu.rdd_en), 64'(0));
            end
            if (mvu.wrd_en) begin
                if (wq.size() == 0) begin
                    n_extra++;
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    check("wr_addr", 64'(mvu.wrd_addr), 64'(w.addr));
                    if (w.first) check("wr_first_cyc", 64'(cyc), 64'(qs_cyc + QLAT));
                    else         check("wr_cyc", 64'(cyc), 64'(last_wr_cyc + 1));
                    if (w.last) next_first_cyc = cyc + 1;
                end
                last_wr_cyc = cyc;
                n_writes++;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            prev_rdd = mvu.rdd_en;
        end
    end

    task automatic run_job(input int w, input int d, input int nt, input int wb, input int db,
                           input int ob, input int qm, input int qb, input int mm,
                           input int stall_at, input int stall_n, input int drop,
                           input bit busy_start, input int rst_wr);
        int we, de, exp_done, c0, tot_iss;
        bit seen, aborted, exp_err;
        iss_t e;
        wr_t  wr;
        we = (w == 0) ? 1 : w;
        de = (d == 0) ? 1 : d;
        iq.delete();
        wq.delete();
        for (int t = 0; t < nt; t++) begin
            for (int s = we + de - 2; s >= 0; s--) begin
                int ihi, ilo;
                ihi = (s < we - 1) ? s : we - 1;
                ilo = (s - de + 1 > 0) ? s - de + 1 : 0;
                for (int i = ihi; i >= ilo; i--) begin
                    e.rdw  = BWBANKA'(wb + t * we + i);
                    e.rdd  = BDBANKA'(db + s - i);
                    e.clr  = (s == we + de - 2) && (i == ihi);
                    e.sh   = (s != we + de - 2) && (i == ihi);
                    e.qclr = e.clr;
                    iq.push_back(e);
                end
            end
            for (int k = 0; k <= qb; k++) begin
                wr.addr  = BDBANKA'(ob + t * (qb + 1) + k);
                wr.first = (k == 0);
                wr.last  = (k == qb);
                wq.push_back(wr);
            end
        end
        tot_iss = nt * we * de;
        exp_err = (drop >= 0) && (drop < nt * (qb + 1));
        n_grant = 0; n_writes = 0; n_qs = 0; n_done = 0; n_extra = 0; prev_rdd = 0;
        hold_issue = stall_at; hold_left = stall_n; drop_wr = drop;

        @(posedge clk);
        #1;
        cfg_wprec    = PRECW'(w);
        cfg_dprec    = PRECW'(d);
        cfg_ntile    = 8'(nt);
        cfg_wbase    = BWBANKA'(wb);
        cfg_dbase    = BDBANKA'(db);
        cfg_obase    = BDBANKA'(ob);
        cfg_qmsbidx  = QMSBLOCBD'(qm);
        cfg_qbdout   = QBDOUTBD'(qb);
        cfg_mul_mode = 2'(mm);
        start = 1'b1;
        c0 = cyc;
        next_first_cyc = c0 + 1;
        exp_done = c0 + 1 + nt * (we * de + PIPE_LAT + QLAT + qb)
                 + ((stall_at >= 0 && stall_at < tot_iss) ? stall_n : 0);
        mon_en = 1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("err_clr", 64'(err), 64'(0));
        check("busy_on", 64'(busy), 64'(nt != 0));

        seen = 0;
        aborted = 0;
        for (int n = 0; n < 3000 && !seen && !aborted; n++) begin
            @(posedge clk);
            #1;
            if (busy_start && n == 1) begin
                start        = 1'b1;
                cfg_mul_mode = ~cfg_mul_mode;
                cfg_qmsbidx  = ~cfg_qmsbidx;
                cfg_qbdout   = cfg_qbdout + 1'b1;
                cfg_wbase    = cfg_wbase + 9'd7;
            end
            if (busy_start && n == 2) start = 1'b0;
            if (rst_wr >= 0 && n_writes == rst_wr + 1 && mvu.wrd_en) begin
                rst_n  = 1'b0;
                mon_en = 0;
                @(posedge clk);
                #1;
                check_reset_outs("midrst");
                rst_n   = 1'b1;
                aborted = 1;
            end
            if (n_done != 0) seen = 1;
        end

        if (!aborted) begin
            check("done_seen", 64'(seen), 64'(1));
            check("done_cyc", 64'(done_cyc), 64'(exp_done));
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            check("done_pulses", 64'(n_done), 64'(1));
            check("qs_pulses", 64'(n_qs), 64'(nt));
            check("iss_left", 64'(iq.size()), 64'(0));
            check("wr_left", 64'(wq.size()), 64'(0));
            check("extra_events", 64'(n_extra), 64'(0));
            check("busy_off", 64'(busy), 64'(0));
            check("err", 64'(err), 64'(exp_err));
            check("mul_mode", 64'(mvu.mul_mode), 64'(mm));
            check("qmsbidx", 64'(mvu.quant_msbidx), 64'(qm));
            check("qbdout", 64'(mvu.quant_bdout), 64'(qb));
            check("max_tied", 64'({mvu.max_en, mvu.max_clr, mvu.max_pool}), 64'(0));
        end
        mon_en = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("reset");
        rst_n = 1'b1;

        //       w  d  nt  wb    db     ob     qm qb mm stall   drop bs rst
        run_job(1, 1, 1,  5,    100,   200,   7, 1, 2, -1, 0, -1, 0, -1);
        run_job(2, 2, 1,  0,    0,     10,    3, 2, 1, -1, 0, -1, 0, -1);
        run_job(2, 2, 1,  0,    0,     10,    3, 2, 1,  1, 3, -1, 0, -1);
        run_job(2, 1, 3,  0,    20,    50,    1, 0, 3, -1, 0, -1, 0, -1);
        run_job(3, 2, 2,  508,  16383, 16383, 9, 3, 1,  4, 2,  1, 1, -1);
        run_job(1, 1, 0,  0,    0,     0,     4, 2, 2, -1, 0, -1, 0, -1);
        run_job(0, 0, 2,  33,   7,     90,    5, 1, 0, -1, 0, -1, 0, -1);
        run_job(1, 1, 2,  0,    0,     0,     2, 1, 1, -1, 0,  0, 0,  2);
        run_job(3, 3, 2,  17,   33,    49,    6, 1, 2,  0, 1, -1, 0, -1);
        run_job(15, 15, 1, 300, 1000,  2000,  31, 4, 3, -1, 0, -1, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
